// File: rtl/operand_forward_ctrl.sv
// Forwarding/hazard control for the two EX-stage operand muxes.
// Tracks in-flight destinations, registers mux selects for the EX cycle and raises load-use stalls.
module operand_forward_ctrl #(
  parameter int REG_ADDR_W   = 5,
  parameter bit HAS_ZERO_REG = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_id_valid,
  input  logic [REG_ADDR_W-1:0] i_id_rs,
  input  logic [REG_ADDR_W-1:0] i_id_rt,
  input  logic                  i_id_use_rs,
  input  logic                  i_id_use_rt,
  input  logic                  i_id_use_imm,
  input  logic [REG_ADDR_W-1:0] i_id_rd,
  input  logic                  i_id_wr_en,
  input  logic                  i_id_is_load,
  input  logic                  i_flush,
  input  logic                  i_hold,
  output logic [1:0]            o_fwd_a_sel,
  output logic [1:0]            o_fwd_b_sel,
  output logic                  o_stall,
  output logic                  o_ex_valid
);

  localparam logic [1:0] SEL_RF    = 2'b00;
  localparam logic [1:0] SEL_EXMEM = 2'b01;
  localparam logic [1:0] SEL_MEMWB = 2'b10;
  localparam logic [1:0] SEL_IMM   = 2'b11;

  // A writer in the wb slot has retired by the consumer's EX cycle (write-through
  // regfile), so only ex and mem shadows influence selects; mem never needs is_load.
  logic                  r_ex_valid;
  logic [REG_ADDR_W-1:0] r_ex_rd;
  logic                  r_ex_wr_en;
  logic                  r_ex_is_load;
  logic                  r_mem_valid;
  logic [REG_ADDR_W-1:0] r_mem_rd;
  logic                  r_mem_wr_en;
  logic [1:0]            r_fwd_a_sel;
  logic [1:0]            r_fwd_b_sel;
  logic                  r_out_valid;

  logic       w_rs_ex;
  logic       w_rs_mem;
  logic       w_rt_ex;
  logic       w_rt_mem;
  logic       w_stall;
  logic       w_issue;
  logic [1:0] w_a_next;
  logic [1:0] w_b_next;

  function automatic logic f_match(
    input logic [REG_ADDR_W-1:0] s,
    input logic                  v,
    input logic                  wr,
    input logic [REG_ADDR_W-1:0] rd
  );
    f_match = v & wr & (s == rd) & ~(HAS_ZERO_REG & (rd == '0));
  endfunction

  always_comb begin
    w_rs_ex  = i_id_use_rs & f_match(i_id_rs, r_ex_valid, r_ex_wr_en, r_ex_rd);
    w_rs_mem = i_id_use_rs & f_match(i_id_rs, r_mem_valid, r_mem_wr_en, r_mem_rd);
    w_rt_ex  = i_id_use_rt & f_match(i_id_rt, r_ex_valid, r_ex_wr_en, r_ex_rd);
    w_rt_mem = i_id_use_rt & f_match(i_id_rt, r_mem_valid, r_mem_wr_en, r_mem_rd);

    // Store data (rt with immediate operand B) is excluded from the load-use check.
    w_stall = i_id_valid & ~i_flush & r_ex_valid & r_ex_is_load &
              (w_rs_ex | (w_rt_ex & ~i_id_use_imm));
    w_issue = i_id_valid & ~w_stall & ~i_flush & ~i_hold;

    w_a_next = SEL_RF;
    if (w_rs_ex)       w_a_next = SEL_EXMEM;
    else if (w_rs_mem) w_a_next = SEL_MEMWB;

    w_b_next = SEL_RF;
    if (i_id_use_imm)  w_b_next = SEL_IMM;
    else if (w_rt_ex)  w_b_next = SEL_EXMEM;
    else if (w_rt_mem) w_b_next = SEL_MEMWB;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ex_valid   <= 1'b0;
      r_ex_rd      <= '0;
      r_ex_wr_en   <= 1'b0;
      r_ex_is_load <= 1'b0;
      r_mem_valid  <= 1'b0;
      r_mem_rd     <= '0;
      r_mem_wr_en  <= 1'b0;
      r_fwd_a_sel  <= SEL_RF;
      r_fwd_b_sel  <= SEL_RF;
      r_out_valid  <= 1'b0;
    end else if (!i_hold) begin
      r_mem_valid  <= r_ex_valid;
      r_mem_rd     <= r_ex_rd;
      r_mem_wr_en  <= r_ex_wr_en;
      r_ex_valid   <= w_issue;
      r_ex_rd      <= w_issue ? i_id_rd : '0;
      r_ex_wr_en   <= w_issue & i_id_wr_en;
      r_ex_is_load <= w_issue & i_id_is_load;
      r_fwd_a_sel  <= w_issue ? w_a_next : SEL_RF;
      r_fwd_b_sel  <= w_issue ? w_b_next : SEL_RF;
      r_out_valid  <= w_issue;
    end
  end

  assign o_fwd_a_sel = r_fwd_a_sel;
  assign o_fwd_b_sel = r_fwd_b_sel;
  assign o_stall     = w_stall;
  assign o_ex_valid  = r_out_valid;

endmodule

// File: tb/tb_operand_forward_ctrl.sv
// Self-checking bench for operand_forward_ctrl: per-cycle instruction stimulus,
// expected EX-cycle outputs queued at drive time and compared after the clock edge.
module tb_operand_forward_ctrl;

  typedef struct {
    logic       rst;
    logic       valid;
    logic [4:0] rd;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic       use_imm;
    logic       wr_en;
    logic       is_load;
    logic       flush;
    logic       hold;
    logic       es;
    logic       ev;
    logic [1:0] ea;
    logic [1:0] eb;
  } stim_t;

  typedef struct {
    logic       v;
    logic [1:0] a;
    logic [1:0] b;
  } out_t;

  logic       clk;
  logic       i_rst;
  logic       i_id_valid;
  logic [4:0] i_id_rs;
  logic [4:0] i_id_rt;
  logic       i_id_use_rs;
  logic       i_id_use_rt;
  logic       i_id_use_imm;
  logic [4:0] i_id_rd;
  logic       i_id_wr_en;
  logic       i_id_is_load;
  logic       i_flush;
  logic       i_hold;
  logic [1:0] o_fwd_a_sel;
  logic [1:0] o_fwd_b_sel;
  logic       o_stall;
  logic       o_ex_valid;

  int   n_checks = 0;
  int   n_errors = 0;
  out_t sb[$];

  operand_forward_ctrl #(.REG_ADDR_W(5), .HAS_ZERO_REG(1'b1)) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_id_valid   (i_id_valid),
    .i_id_rs      (i_id_rs),
    .i_id_rt      (i_id_rt),
    .i_id_use_rs  (i_id_use_rs),
    .i_id_use_rt  (i_id_use_rt),
    .i_id_use_imm (i_id_use_imm),
    .i_id_rd      (i_id_rd),
    .i_id_wr_en   (i_id_wr_en),
    .i_id_is_load (i_id_is_load),
    .i_flush      (i_flush),
    .i_hold       (i_hold),
    .o_fwd_a_sel  (o_fwd_a_sel),
    .o_fwd_b_sel  (o_fwd_b_sel),
    .o_stall      (o_stall),
    .o_ex_valid   (o_ex_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t mk(input logic v, input logic [4:0] rd, input logic [4:0] rs,
                               input logic [4:0] rt, input logic urs, input logic urt,
                               input logic uimm, input logic wr, input logic ld);
    stim_t s;
    s.rst = 1'b0; s.valid = v; s.rd = rd; s.rs = rs; s.rt = rt;
    s.use_rs = urs; s.use_rt = urt; s.use_imm = uimm; s.wr_en = wr; s.is_load = ld;
    s.flush = 1'b0; s.hold = 1'b0;
    s.es = 1'b0; s.ev = 1'b0; s.ea = 2'b00; s.eb = 2'b00;
    return s;
  endfunction

  function automatic stim_t alu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    return mk(1'b1, rd, rs, rt, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
  endfunction
  function automatic stim_t immop(input logic [4:0] rd, input logic [4:0] rs);
    return mk(1'b1, rd, rs, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
  endfunction
  function automatic stim_t load(input logic [4:0] rd, input logic [4:0] rs);
    return mk(1'b1, rd, rs, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
  endfunction
  function automatic stim_t store(input logic [4:0] rs, input logic [4:0] rt);
    return mk(1'b1, 5'd0, rs, rt, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
  endfunction
  function automatic stim_t idle();
    return mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic stim_t ctl(input stim_t s, input logic rst, input logic flush, input logic hold);
    stim_t r = s;
    r.rst = rst; r.flush = flush; r.hold = hold;
    return r;
  endfunction

  function automatic stim_t want(input stim_t s, input logic st, input logic v,
                                 input logic [1:0] a, input logic [1:0] b);
    stim_t r = s;
    r.es = st; r.ev = v; r.ea = a; r.eb = b;
    return r;
  endfunction

  task automatic apply(input stim_t s);
    i_rst = s.rst; i_id_valid = s.valid; i_id_rd = s.rd; i_id_rs = s.rs; i_id_rt = s.rt;
    i_id_use_rs = s.use_rs; i_id_use_rt = s.use_rt; i_id_use_imm = s.use_imm;
    i_id_wr_en = s.wr_en; i_id_is_load = s.is_load; i_flush = s.flush; i_hold = s.hold;
  endtask

  task automatic do_reset();
    @(negedge clk);
    apply(ctl(idle(), 1'b1, 1'b0, 1'b0));
    @(posedge clk);
    sb.delete();
  endtask

  task automatic test_reset();
    out_t e;
    @(negedge clk);
    apply(ctl(alu(5'd3, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0));
    repeat (2) @(posedge clk);
    #1;
    e.v = 1'b0; e.a = 2'b00; e.b = 2'b00;
    n_checks++;
    if ({o_ex_valid, o_fwd_a_sel, o_fwd_b_sel} !== {e.v, e.a, e.b}) begin
      n_errors++;
      $display("FAIL reset_outputs: got v=%b a=%b b=%b want v=0 a=00 b=00",
               o_ex_valid, o_fwd_a_sel, o_fwd_b_sel);
    end
    n_checks++;
    if (o_stall !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_stall: got %b want 0", o_stall);
    end
  endtask

  task automatic test_ex_forward();
    stim_t seq[$];
    out_t  e;
    out_t  got;
    do_reset();
    seq.push_back(want(alu(5'd3, 5'd1, 5'd2), 1'b0, 1'b1, 2'b00, 2'b00));
    seq.push_back(want(alu(5'd4, 5'd3, 5'd5), 1'b0, 1'b1, 2'b01, 2'b00));
    seq.push_back(want(alu(5'd6, 5'd7, 5'd4), 1'b0, 1'b1, 2'b00, 2'b01));
    seq.push_back(want(idle(), 1'b0, 1'b0, 2'b00, 2'b00));
    foreach (seq[i]) begin
      @(negedge clk);
      apply(seq[i]);
      e.v = seq[i].ev; e.a = seq[i].ea; e.b = seq[i].eb;
      sb.push_back(e);
      #1;
      n_checks++;
      if (o_stall !== seq[i].es) begin
        n_errors++;
        $display("FAIL ex_forward stall c%0d: got %b want %b", i, o_stall, seq[i].es);
      end
      @(posedge clk);
      #1;
      got = sb.pop_front();
      n_checks++;
      if ({o_ex_valid, o_fwd_a_sel, o_fwd_b_sel} !== {got.v, got.a, got.b}) begin
        n_errors++;
        $display("FAIL ex_forward out c%0d: got v=%b a=%b b=%b want v=%b a=%b b=%b",
                 i, o_ex_valid, o_fwd_a_sel, o_fwd_b_sel, got.v, got.a, got.b);
      end
    end
  endtask

  task automatic test_mem_forward();
    stim_t seq[$];
    out_t  e;
    out_t  got;
    do_reset();
    seq.push_back(want(alu(5'd3, 5'd1, 5'd2), 1'b0, 1'b1, 2'b00, 2'b00));
    seq.push_back(want(idle(), 1'b0, 1'b0, 2'b00, 2'b00));
    seq.push_back(want(alu(5'd6, 5'd7, 5'd3), 1'b0, 1'b1, 2'b00, 2'b10));
    // r3 now sits in wb: retired by EX, so regfile; r6 is in ex
    seq.push_back(want(alu(5'd8, 5'd3, 5'd6), 1'b0, 1'b1, 2'b00, 2'b01));
    seq.push_back(want(idle(), 1'b0, 1'b0, 2'b00, 2'b00));
    foreach (seq[i]) begin
      @(negedge clk);
      apply(seq[i]);
      e.v = seq[i].ev; e.a = seq[i].ea; e.b = seq[i].eb;
      sb.push_back(e);
      #1;
      n_checks++;
      if (o_stall !== seq[i].es) begin
        n_errors++;
        $display("FAIL mem_forward stall c%0d: got %b want %b", i, o_stall, seq[i].es);
      end
      @(posedge clk);
      #1;
      got = sb.pop_front();
      n_checks++;
      if ({o_ex_valid, o_fwd_a_sel, o_fwd_b_sel} !== {got.v, got.a, got.b}) begin
        n_errors++;
        $display("FAIL mem_forward out c%0d: got v=%b a=%b b=%b want v=%b a=%b b=%b",
                 i, o_ex_valid, o_fwd_a_sel, o_fwd_b_sel, got.v, got.a, got.b);
      end
    end
  endtask

  task automatic test_load_use();
    stim_t seq[$];
    out_t  e;
    out_t  got;
    do_reset();
    seq.push_back(want(load(5'd8, 5'd1), 1'b0, 1'b1, 2'b00, 2'b11));
    seq.push_back(want(alu(5'd9, 5'd8, 5'd8), 1'b1, 1'b0, 2'b00, 2'b00));
    seq.push_back(want(alu(5'd9, 5'd8, 5'd8), 1'b0, 1'b1, 2'b10, 2'b10));
    seq.push_back(want(load(5'd10, 5'd2), 1'b0, 1'b1, 2'b00, 2'b11));
    // store data from a just-loaded reg does not stall
    seq.push_back(want(store(5'd2, 5'd10), 1'b0, 1'b1, 2'b00, 2'b11));
    seq.push_back(want(idle(), 1'b0, 1'b0, 2'b00, 2'b00));
    foreach (seq[i]) begin
      @(negedge clk);
      apply(seq[i]);
      e.v = seq[i].ev; e.a = seq[i].ea; e.b = seq[i].eb;
      sb.push_back(e);
      #1;
      n_checks++;
      if (o_stall !== seq[i].es) begin
        n_errors++;
        $display("FAIL load_use stall c%0d: got %b want %b", i, o_stall, seq[i].es);
      end
      @(posedge clk);
      #1;
      got = sb.pop_front();
      n_checks++;
      if ({o_ex_valid, o_fwd_a_sel, o_fwd_b_sel} !== {got.v, got.a, got.b}) begin
        n_errors++;
        $display("FAIL load_use out c%0d: got v=%b a=%b b=%b want v=%b a=%b b=%b",
                 i, o_ex_valid, o_fwd_a_sel, o_fwd_b_sel, got.v, got.a, got.b);
      end
    end
  endtask

  task automatic test_zero_reg_imm();
    stim_t seq[$];
    out_t  e;
    out_t  got;
    do_reset();
    seq.push_back(want(alu(5'd0, 5'd1, 5'd2), 1'b0, 1'b1, 2'b00, 2'b00));
    seq.push_back(want(alu(5'd4, 5'd0, 5'd0), 1'b0, 1'b1, 2'b00, 2'b00));
    seq.push_back(want(immop(5'd5, 5'd4), 1'b0, 1'b1, 2'b01, 2'b11));
    seq.push_back(want(mk(1'b1, 5'd6, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0),
                       1'b0, 1'b1, 2'b00, 2'b11));
    seq.push_back(want(idle(), 1'b0, 1'b0, 2'b00, 2'b00));
    foreach (seq[i]) begin
      @(negedge clk);
      apply(seq[i]);
      e.v = seq[i].ev; e.a = seq[i].ea; e.b = seq[i].eb;
      sb.push_back(e);
      #1;
      n_checks++;
      if (o_stall !== seq[i].es) begin
        n_errors++;
        $display("FAIL zero_reg stall c%0d: got %b want %b", i, o_stall, seq[i].es);
      end
      @(posedge clk);
      #1;
      got = sb.pop_front();
      n_checks++;
      if ({o_ex_valid, o_fwd_a_sel, o_fwd_b_sel} !== {got.v, got.a, got.b}) begin
        n_errors++;
        $display("FAIL zero_reg out c%0d: got v=%b a=%b b=%b want v=%b a=%b b=%b",
                 i, o_ex_valid, o_fwd_a_sel, o_fwd_b_sel, got.v, got.a, got.b);
      end
    end
  endtask

  task automatic test_back_to_back_hold();
    stim_t seq[$];
    out_t  e;
    out_t  got;
    do_reset();
    seq.push_back(want(alu(5'd3, 5'd1, 5'd2), 1'b0, 1'b1, 2'b00, 2'b00));
    seq.push_back(want(alu(5'd3, 5'd1, 5'd2), 1'b0, 1'b1, 2'b00, 2'b00));
    seq.push_back(want(alu(5'd5, 5'd3, 5'd3), 1'b0, 1'b1, 2'b01, 2'b01));
    // hold + flush together: hold wins, everything frozen
    seq.push_back(want(ctl(alu(5'd7, 5'd5, 5'd3), 1'b0, 1'b0, 1'b1), 1'b0, 1'b1, 2'b01, 2'b01));
    seq.push_back(want(ctl(alu(5'd7, 5'd5, 5'd3), 1'b0, 1'b1, 1'b1), 1'b0, 1'b1, 2'b01, 2'b01));
    seq.push_back(want(ctl(alu(5'd7, 5'd5, 5'd3), 1'b0, 1'b0, 1'b1), 1'b0, 1'b1, 2'b01, 2'b01));
    seq.push_back(want(alu(5'd7, 5'd5, 5'd3), 1'b0, 1'b1, 2'b01, 2'b10));
    seq.push_back(want(idle(), 1'b0, 1'b0, 2'b00, 2'b00));
    foreach (seq[i]) begin
      @(negedge clk);
      apply(seq[i]);
      e.v = seq[i].ev; e.a = seq[i].ea; e.b = seq[i].eb;
      sb.push_back(e);
      #1;
      n_checks++;
      if (o_stall !== seq[i].es) begin
        n_errors++;
        $display("FAIL hold stall c%0d: got %b want %b", i, o_stall, seq[i].es);
      end
      @(posedge clk);
      #1;
      got = sb.pop_front();
      n_checks++;
      if ({o_ex_valid, o_fwd_a_sel, o_fwd_b_sel} !== {got.v, got.a, got.b}) begin
        n_errors++;
        $display("FAIL hold out c%0d: got v=%b a=%b b=%b want v=%b a=%b b=%b",
                 i, o_ex_valid, o_fwd_a_sel, o_fwd_b_sel, got.v, got.a, got.b);
      end
    end
  endtask

  task automatic test_flush_rst_stall();
    stim_t seq[$];
    out_t  e;
    out_t  got;
    do_reset();
    seq.push_back(want(load(5'd8, 5'd1), 1'b0, 1'b1, 2'b00, 2'b11));
    seq.push_back(want(ctl(alu(5'd9, 5'd8, 5'd8), 1'b0, 1'b1, 1'b0), 1'b0, 1'b0, 2'b00, 2'b00));
    seq.push_back(want(idle(), 1'b0, 1'b0, 2'b00, 2'b00));
    seq.push_back(want(load(5'd8, 5'd1), 1'b0, 1'b1, 2'b00, 2'b11));
    // stall from frozen load while holding, then reset mid-stall
    seq.push_back(want(ctl(alu(5'd9, 5'd8, 5'd8), 1'b0, 1'b0, 1'b1), 1'b1, 1'b1, 2'b00, 2'b11));
    seq.push_back(want(ctl(alu(5'd9, 5'd8, 5'd8), 1'b1, 1'b0, 1'b0), 1'b1, 1'b0, 2'b00, 2'b00));
    seq.push_back(want(alu(5'd9, 5'd8, 5'd8), 1'b0, 1'b1, 2'b00, 2'b00));
    seq.push_back(want(idle(), 1'b0, 1'b0, 2'b00, 2'b00));
    foreach (seq[i]) begin
      @(negedge clk);
      apply(seq[i]);
      e.v = seq[i].ev; e.a = seq[i].ea; e.b = seq[i].eb;
      sb.push_back(e);
      #1;
      n_checks++;
      if (o_stall !== seq[i].es) begin
        n_errors++;
        $display("FAIL flush_rst stall c%0d: got %b want %b", i, o_stall, seq[i].es);
      end
      @(posedge clk);
      #1;
      got = sb.pop_front();
      n_checks++;
      if ({o_ex_valid, o_fwd_a_sel, o_fwd_b_sel} !== {got.v, got.a, got.b}) begin
        n_errors++;
        $display("FAIL flush_rst out c%0d: got v=%b a=%b b=%b want v=%b a=%b b=%b",
                 i, o_ex_valid, o_fwd_a_sel, o_fwd_b_sel, got.v, got.a, got.b);
      end
    end
  endtask

  initial begin
    apply(ctl(idle(), 1'b1, 1'b0, 1'b0));
    test_reset();
    test_ex_forward();
    test_mem_forward();
    test_load_use();
    test_zero_reg_imm();
    test_back_to_back_hold();
    test_flush_rst_stall();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
